cruise_driver_cmd_encoder: RTL and testbench

- Driver-side front end for the cruise controller: converts raw stalk buttons and pedal switches into the clean control inputs the controller consumes.
- Outputs: single-cycle command pulses for set, accel, coast, cancel and resume; synchronized level signals for throttle and brake.
- Debounces every button, arbitrates simultaneous presses and auto-repeats held accel/coast.
- Sits between the switch pins and the controller's command inputs.

---
 rtl/cruise_driver_cmd_encoder.sv | 178 +++++++++++++++++
 tb/tb_cruise_driver_cmd_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cruise_driver_cmd_encoder.sv
// Cruise controller driver front end: synchronizes switch pins, debounces buttons,
// auto-repeats accel/coast and arbitrates one command pulse per cycle. Optional macro: STUCK_DETECT_EN.
module cruise_driver_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_set,
  input  logic raw_accel,
  input  logic raw_coast,
  input  logic raw_cancel,
  input  logic raw_resume,
  input  logic raw_throttle,
  input  logic raw_brake,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic throttle,
  output logic brake,
  output logic stuck_fault
);

  localparam int NB       = 5;
  localparam int SET_I    = 0;
  localparam int ACCEL_I  = 1;
  localparam int COAST_I  = 2;
  localparam int CANCEL_I = 3;
  localparam int RESUME_I = 4;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W    = $clog2(RPT_MAX + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || STUCK_CYCLES < 1) begin : g_param_check
    $error("cruise_driver_cmd_encoder: DEBOUNCE_CYCLES, REPEAT_PERIOD and STUCK_CYCLES must be >= 1");
  end

  logic [6:0]      raw_vec;
  logic [6:0]      sync_p0, sync_p1;
  logic [NB-1:0]   deb, deb_d, armed;
  logic [DB_W-1:0] db_cnt [NB];
  logic [RPT_W-1:0] rpt_timer [2];
  logic [RPT_W-1:0] rpt_phase [2];
  logic [1:0]      rpt_fire;
  logic [NB-1:0]   req, grant;

  function automatic logic [NB-1:0] arbitrate(input logic [NB-1:0] r, input logic allow);
    arbitrate = '0;
    if (r[CANCEL_I])                arbitrate[CANCEL_I] = 1'b1;
    else if (allow) begin
      if (r[SET_I])                 arbitrate[SET_I]    = 1'b1;
      else if (r[RESUME_I])         arbitrate[RESUME_I] = 1'b1;
      else if (r[ACCEL_I])          arbitrate[ACCEL_I]  = 1'b1;
      else if (r[COAST_I])          arbitrate[COAST_I]  = 1'b1;
    end
  endfunction

  assign raw_vec = {raw_brake, raw_throttle, raw_resume, raw_cancel, raw_coast, raw_accel, raw_set};

  // p0 -> p1: two-flop synchronizer for every pin
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_vec;
      sync_p1 <= sync_p0;
    end
  end

  // p1 -> debounced state; after reset a button must be seen low long enough before it can arm
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      deb_d <= '0;
      armed <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < NB; i++) begin
        if (!armed[i]) begin
          if (sync_p1[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            armed[i]  <= 1'b1;
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else if (sync_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Repeat timer saturates at the delay; the phase counter then spaces the repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        rpt_timer[j] <= '0;
        rpt_phase[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!deb[j+1]) begin
          rpt_timer[j] <= '0;
          rpt_phase[j] <= '0;
        end else if (rpt_timer[j] != RPT_W'(REPEAT_DELAY)) begin
          rpt_timer[j] <= rpt_timer[j] + 1'b1;
        end else if (rpt_phase[j] == RPT_W'(REPEAT_PERIOD - 1)) begin
          rpt_phase[j] <= '0;
        end else begin
          rpt_phase[j] <= rpt_phase[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rpt_fire = '0;
    for (int j = 0; j < 2; j++)
      rpt_fire[j] = deb[j+1] && (rpt_timer[j] == RPT_W'(REPEAT_DELAY)) && (rpt_phase[j] == '0);
  end

  assign req   = (deb & ~deb_d) | {2'b00, rpt_fire, 1'b0};
  assign grant = arbitrate(req, ~brake & ~stuck_fault);

  // p1 -> outputs: registered command pulses and pedal levels
  always_ff @(posedge clk) begin
    if (reset) begin
      {resume, cancel, coast, accel, set} <= '0;
      throttle <= 1'b0;
      brake    <= 1'b0;
    end else begin
      {resume, cancel, coast, accel, set} <= grant;
      throttle <= sync_p1[5];
      brake    <= sync_p1[6];
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int ST_W = $clog2(STUCK_CYCLES + 1);
  logic [ST_W-1:0] held [NB];
  logic            stuck_hit;

  always_comb begin
    stuck_hit = 1'b0;
    for (int i = 0; i < NB; i++)
      if (held[i] == ST_W'(STUCK_CYCLES)) stuck_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_fault <= 1'b0;
      for (int i = 0; i < NB; i++) held[i] <= '0;
    end else begin
      stuck_fault <= stuck_fault | stuck_hit;
      for (int i = 0; i < NB; i++) begin
        if (!deb[i])                             held[i] <= '0;
        else if (held[i] != ST_W'(STUCK_CYCLES)) held[i] <= held[i] + 1'b1;
      end
    end
  end
`else
  assign stuck_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cruise_driver_cmd_encoder.sv
// Bench for cruise_driver_cmd_encoder: directed scenarios plus random pin activity,
// compared cycle by cycle against a window-based reference model of the switch rules.
module tb_cruise_driver_cmd_encoder;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int SC = 64;

  localparam logic [6:0] P_SET = 7'b0000001;
  localparam logic [6:0] P_ACC = 7'b0000010;
  localparam logic [6:0] P_CST = 7'b0000100;
  localparam logic [6:0] P_CAN = 7'b0001000;
  localparam logic [6:0] P_RES = 7'b0010000;
  localparam logic [6:0] P_BRK = 7'b1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_set = 0, raw_accel = 0, raw_coast = 0, raw_cancel = 0, raw_resume = 0;
  logic raw_throttle = 0, raw_brake = 0;
  logic set, accel, coast, cancel, resume, throttle, brake, stuck_fault;

  always #5 clk = ~clk;

  cruise_driver_cmd_encoder #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .STUCK_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset),
    .raw_set(raw_set), .raw_accel(raw_accel), .raw_coast(raw_coast),
    .raw_cancel(raw_cancel), .raw_resume(raw_resume),
    .raw_throttle(raw_throttle), .raw_brake(raw_brake),
    .set(set), .accel(accel), .coast(coast), .cancel(cancel), .resume(resume),
    .throttle(throttle), .brake(brake), .stuck_fault(stuck_fault)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: synchronizer delay line, then per-button sample windows.
  logic [6:0] m_s1, m_s2;
  logic [4:0] m_deb, m_deb_d, m_arm;
  bit         m_hist [5][$];
  int         m_k [5];
  int         m_held [5];
  logic       m_brk, m_fault;
  logic [4:0] e_pulse;
  logic       e_thr, e_brk, e_fault;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0; m_arm = '0;
    m_brk = 1'b0; m_fault = 1'b0;
    for (int b = 0; b < 5; b++) begin
      m_hist[b].delete();
      m_k[b] = 0;
      m_held[b] = 0;
    end
    e_pulse = '0; e_thr = 1'b0; e_brk = 1'b0; e_fault = 1'b0;
  endtask

  task automatic model_step(input logic [6:0] r);
    logic [4:0] req, deb_new, arm_new;
    int order [4] = '{0, 4, 1, 2};
    bit all_low, all_diff;
    deb_new = m_deb;
    arm_new = m_arm;
    for (int b = 0; b < 5; b++) begin
      m_hist[b].push_back(m_s2[b]);
      if (m_hist[b].size() > D) void'(m_hist[b].pop_front());
      all_low = 1; all_diff = 1;
      foreach (m_hist[b][i]) begin
        if (m_hist[b][i] != 0) all_low = 0;
        if (m_hist[b][i] == m_deb[b]) all_diff = 0;
      end
      if (m_hist[b].size() == D) begin
        if (!m_arm[b]) begin
          if (all_low) arm_new[b] = 1'b1;
        end else if (all_diff) begin
          deb_new[b] = ~m_deb[b];
        end
      end
    end
    req = m_deb & ~m_deb_d;
    for (int b = 1; b <= 2; b++)
      if (m_deb[b] && m_k[b] >= RD && ((m_k[b] - RD) % RP) == 0) req[b] = 1'b1;
    e_pulse = '0;
    if (req[3]) e_pulse[3] = 1'b1;
    else if (!m_brk && !m_fault) begin
      for (int i = 0; i < 4; i++)
        if (e_pulse == '0 && req[order[i]]) e_pulse[order[i]] = 1'b1;
    end
    e_thr = m_s2[5];
    e_brk = m_s2[6];
`ifdef STUCK_DETECT_EN
    e_fault = m_fault;
    for (int b = 0; b < 5; b++) if (m_held[b] == SC) e_fault = 1'b1;
    for (int b = 0; b < 5; b++) m_held[b] = m_deb[b] ? ((m_held[b] < SC) ? m_held[b] + 1 : SC) : 0;
`else
    e_fault = 1'b0;
`endif
    for (int b = 0; b < 5; b++) m_k[b] = m_deb[b] ? m_k[b] + 1 : 0;
    m_deb_d = m_deb;
    m_deb   = deb_new;
    m_arm   = arm_new;
    m_s2    = m_s1;
    m_s1    = r;
    m_brk   = e_brk;
    m_fault = e_fault;
  endtask

  int obs_cnt [5];
  int obs_last [5];
  int brk_rise = -1;
  logic brk_prev = 1'b0;
  int acc_q [$];

  task automatic clear_obs();
    for (int b = 0; b < 5; b++) begin
      obs_cnt[b] = 0;
      obs_last[b] = -1;
    end
    acc_q.delete();
    brk_rise = -1;
  endtask

  task automatic tick(input logic rst_v, input logic [6:0] r);
    logic [4:0] p;
    @(negedge clk);
    reset = rst_v;
    {raw_brake, raw_throttle, raw_resume, raw_cancel, raw_coast, raw_accel, raw_set} = r;
    if (rst_v) model_reset();
    else model_step(r);
    @(posedge clk);
    #1;
    p = {resume, cancel, coast, accel, set};
    check("cmd", 32'(p), 32'(e_pulse));
    check("pedal", {30'd0, brake, throttle}, {30'd0, e_brk, e_thr});
    check("stuck", 32'(stuck_fault), 32'(e_fault));
    for (int b = 0; b < 5; b++)
      if (p[b] === 1'b1) begin
        obs_cnt[b]++;
        obs_last[b] = cyc;
      end
    if (accel === 1'b1) acc_q.push_back(cyc);
    if (brake === 1'b1 && brk_prev !== 1'b1 && brk_rise < 0) brk_rise = cyc;
    brk_prev = brake;
    cyc++;
  endtask

  task automatic hold(input logic [6:0] r, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, r);
  endtask

  task automatic do_reset();
    tick(1'b1, '0);
    tick(1'b1, '0);
    hold('0, 8);
  endtask

  initial begin
    int c0;
    logic [6:0] rv;
    model_reset();
    tick(1'b1, '0);
    check("reset_outs", {24'd0, set, accel, coast, cancel, resume, throttle, brake, stuck_fault}, 32'd0);
    tick(1'b1, '0);
    hold('0, 8);

    // set press: one pulse, DEBOUNCE_CYCLES+2 edges after first sample
    clear_obs();
    c0 = cyc;
    hold(P_SET, 10);
    hold('0, 10);
    check("set_count", obs_cnt[0], 1);
    check("set_latency", obs_last[0] - c0, D + 2);
    check("set_others", obs_cnt[1] + obs_cnt[2] + obs_cnt[3] + obs_cnt[4], 0);

    // accel glitches shorter than the debounce window, then a real press
    clear_obs();
    hold(P_ACC, 1); hold('0, 5);
    hold(P_ACC, 2); hold('0, 5);
    hold(P_ACC, 3); hold('0, 5);
    check("glitch_accel", obs_cnt[1], 0);
    hold(P_ACC, 5); hold('0, 10);
    check("press_accel", obs_cnt[1], 1);

    // cancel beats set on the same cycle; set is dropped
    clear_obs();
    hold(P_CAN | P_SET, 6); hold('0, 10);
    check("arb_cancel", obs_cnt[3], 1);
    check("arb_set_dropped", obs_cnt[0], 0);
    hold(P_SET, 6); hold('0, 10);
    check("later_set", obs_cnt[0], 1);

    // accel held: first pulse, repeat after REPEAT_DELAY, then every REPEAT_PERIOD
    clear_obs();
    hold(P_ACC, 30); hold('0, 15);
    check("rpt_min_pulses", 32'(acc_q.size() >= 4), 1);
    for (int i = 1; i < 4; i++)
      check("rpt_gap", (i < acc_q.size()) ? acc_q[i] - acc_q[i-1] : -1, (i == 1) ? RD : RP);

    // brake interlock: resume suppressed, cancel still issued
    clear_obs();
    c0 = cyc;
    hold(P_BRK, 6);
    check("brake_latency", brk_rise - c0, 2);
    hold(P_BRK | P_RES, 6); hold(P_BRK, 8);
    hold(P_BRK | P_CAN, 6); hold(P_BRK, 8);
    hold('0, 6);
    check("brake_resume", obs_cnt[4], 0);
    check("brake_cancel", obs_cnt[3], 1);

    // reset mid-press: held button must be released and re-pressed
    clear_obs();
    hold(P_SET, 3);
    tick(1'b1, P_SET);
    tick(1'b1, P_SET);
    hold(P_SET, 12);
    check("midpress_none", obs_cnt[0], 0);
    hold('0, 8); hold(P_SET, 6); hold('0, 8);
    check("midpress_after", obs_cnt[0], 1);

`ifdef STUCK_DETECT_EN
    // stuck coast: fault latches, coast stops, cancel survives, only reset clears it
    do_reset();
    clear_obs();
    hold(P_CST, 80);
    check("stuck_set", 32'(stuck_fault), 1);
    hold('0, 8);
    c0 = obs_cnt[2];
    hold(P_CAN, 6); hold('0, 8);
    hold(P_SET, 6); hold('0, 8);
    check("stuck_cancel", obs_cnt[3], 1);
    check("stuck_set_blocked", obs_cnt[0], 0);
    check("stuck_hold", 32'(stuck_fault), 1);
    tick(1'b1, '0);
    check("stuck_clear", 32'(stuck_fault), 0);
    hold('0, 8);
`endif

    // random pin activity, with one reset in the middle
    do_reset();
    rv = '0;
    for (int n = 0; n < 900; n++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 6) == 0) rv[b] = ~rv[b];
      if (n == 450) begin
        tick(1'b1, rv);
        tick(1'b1, rv);
      end else begin
        tick(1'b0, rv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
